// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: fetch-unit bus bundle (pipeline control, imem handshake, IF/ID output triple).
interface ifu_fetch_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   stall_i;
    logic                   redirect_i;
    logic [PC_WIDTH-1:0]    redirect_pc_i;
    logic                   imem_req_valid_o;
    logic                   imem_req_ready_i;
    logic [PC_WIDTH-1:0]    imem_req_addr_o;
    logic                   imem_rsp_valid_i;
    logic [INSTR_WIDTH-1:0] imem_rsp_data_i;
    logic                   if_valid_o;
    logic [PC_WIDTH-1:0]    if_pc_o;
    logic [INSTR_WIDTH-1:0] if_instr_o;
    logic                   if_prdt_taken_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        output imem_req_valid_o, imem_req_addr_o, if_valid_o, if_pc_o, if_instr_o, if_prdt_taken_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        input  imem_req_valid_o, imem_req_addr_o, if_valid_o, if_pc_o, if_instr_o, if_prdt_taken_o
    );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch with out reg + skid slot; IFU_STATIC_BPU_EN enables static prediction.
module ifu_fetch #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input logic          clk,
    input logic          rst,
    ifu_fetch_if.master  f
);
    localparam logic [0:0] S_REQ  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
    logic                   drop_q, drop_d;
    logic                   out_v_q, out_v_d;
    logic [PC_WIDTH-1:0]    out_pc_q, out_pc_d;
    logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
    logic                   out_pred_q, out_pred_d;
    logic                   skid_v_q, skid_v_d;
    logic [PC_WIDTH-1:0]    skid_pc_q, skid_pc_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic                   skid_pred_q, skid_pred_d;
    logic                   req_v, req_fire, push, consume, pop_skid, push_out, push_skid;
    logic                   rsp_pred;
    logic [PC_WIDTH-1:0]    next_pc;

`ifdef IFU_STATIC_BPU_EN
    logic [INSTR_WIDTH-1:0] d;
    logic [PC_WIDTH-1:0]    j_imm, b_imm;
    logic                   is_jal, is_bwd;
    always_comb begin
        d        = f.imem_rsp_data_i;
        j_imm    = {{(PC_WIDTH-21){d[31]}}, d[31], d[19:12], d[20], d[30:21], 1'b0};
        b_imm    = {{(PC_WIDTH-13){d[31]}}, d[31], d[7], d[30:25], d[11:8], 1'b0};
        is_jal   = d[6:0] == 7'b1101111;
        is_bwd   = d[6:0] == 7'b1100011 && d[31];
        rsp_pred = is_jal | is_bwd;
        next_pc  = fetch_pc_q + (is_jal ? j_imm : is_bwd ? b_imm : PC_WIDTH'(4));
    end
`else
    assign rsp_pred = 1'b0;
    assign next_pc  = fetch_pc_q + PC_WIDTH'(4);
`endif

    always_comb begin
        req_v      = ~rst & (state_q == S_REQ) & ~skid_v_q & ~f.redirect_i;
        req_fire   = req_v & f.imem_req_ready_i;
        push       = (state_q == S_WAIT) & f.imem_rsp_valid_i & ~drop_q & ~f.redirect_i;
        consume    = out_v_q & ~f.stall_i;
        pop_skid   = consume & skid_v_q;
        push_out   = push & ~skid_v_q & (~out_v_q | consume);
        push_skid  = push & ~push_out;
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        if (state_q == S_REQ) begin
            state_d = req_fire ? S_WAIT : S_REQ;
        end else if (f.imem_rsp_valid_i) begin
            state_d    = S_REQ;
            drop_d     = 1'b0;
            fetch_pc_d = drop_q ? fetch_pc_q : next_pc;
        end else if (f.redirect_i) begin
            drop_d = 1'b1;
        end
        // fetch_pc already holds the request address while waiting, so it tags the pushed entry
        if (f.redirect_i) fetch_pc_d = f.redirect_pc_i;
        out_v_d      = ~f.redirect_i & (pop_skid | push_out | (out_v_q & ~consume));
        out_pc_d     = pop_skid ? skid_pc_q : push_out ? fetch_pc_q : out_pc_q;
        out_instr_d  = pop_skid ? skid_instr_q : push_out ? f.imem_rsp_data_i : out_instr_q;
        out_pred_d   = pop_skid ? skid_pred_q : push_out ? rsp_pred : out_pred_q;
        skid_v_d     = ~f.redirect_i & (push_skid | (skid_v_q & ~pop_skid));
        skid_pc_d    = push_skid ? fetch_pc_q : skid_pc_q;
        skid_instr_d = push_skid ? f.imem_rsp_data_i : skid_instr_q;
        skid_pred_d  = push_skid ? rsp_pred : skid_pred_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            drop_q       <= 1'b0;
            out_v_q      <= 1'b0;
            out_pc_q     <= '0;
            out_instr_q  <= '0;
            out_pred_q   <= 1'b0;
            skid_v_q     <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pred_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drop_q       <= drop_d;
            out_v_q      <= out_v_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            out_pred_q   <= out_pred_d;
            skid_v_q     <= skid_v_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pred_q  <= skid_pred_d;
        end
    end

    assign f.imem_req_valid_o = req_v;
    assign f.imem_req_addr_o  = req_v ? fetch_pc_q : '0;
    assign f.if_valid_o       = out_v_q;
    assign f.if_pc_o          = out_pc_q;
    assign f.if_instr_o       = out_instr_q;
    assign f.if_prdt_taken_o  = out_pred_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed + randomized bench; reference is a program-order PC chain over a memory image.
module tb_ifu_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_fetch_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();
    ifu_fetch dut (.clk(clk), .rst(rst), .f(bus));

`ifdef IFU_STATIC_BPU_EN
    localparam bit BPU = 1'b1;
`else
    localparam bit BPU = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] ovr [logic [31:0]];
    logic [31:0] tbl [64];
    bit          rnd_fill = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return rnd_fill ? tbl[a[7:2]] : 32'h13;
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins, output logic taken);
        int off;
        taken = 1'b0;
        off   = 4;
`ifdef IFU_STATIC_BPU_EN
        if (ins[6:0] == 7'b1101111) begin
            taken = 1'b1;
            off   = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096 - (ins[31] ? (1 << 20) : 0);
        end else if (ins[6:0] == 7'b1100011 && ins[31]) begin
            taken = 1'b1;
            off   = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048 - 4096;
        end
`endif
        return pc + off;
    endfunction

    bit          rst_k = 1'b1, ready_k = 1'b1, stall_k = 1'b0, rdr_k = 1'b0, rnd = 1'b0;
    logic [31:0] rdr_pc_k = '0;
    int          lat_k = 1;
    bit          pend = 1'b0;
    logic [31:0] pend_addr;
    int          due, cyc = 0, n_hs = 0, n_cons = 0;
    logic [31:0] exp_pc = '0;
    bit          p_rst = 1'b1, p_req, p_rdy, p_if, p_stall, p_rdr, p_pred;
    logic [31:0] p_addr, p_pc, p_ins, p_tgt;

    task automatic step();
        logic        tk;
        logic [31:0] ins;
        @(negedge clk);
        cyc++;
        if (rnd) begin
            ready_k  = ($urandom % 10) < 7;
            stall_k  = ($urandom % 10) < 3;
            rdr_k    = ($urandom % 40) == 0;
            rdr_pc_k = $urandom & 32'hFC;
            lat_k    = 1 + $urandom % 3;
        end
        rst                  = rst_k;
        bus.imem_req_ready_i = ready_k;
        bus.stall_i          = stall_k;
        bus.redirect_i       = rdr_k;
        bus.redirect_pc_i    = rdr_pc_k;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = $urandom;
        if (pend && cyc >= due) begin
            bus.imem_rsp_valid_i = 1'b1;
            bus.imem_rsp_data_i  = mem_rd(pend_addr);
            pend = 1'b0;
        end
        #1;
        if (!rst) begin
            if (!p_rst && p_req && !p_rdy && !rdr_k) begin
                check("req_hold_valid", bus.imem_req_valid_o, 1'b1);
                check("req_hold_addr", bus.imem_req_addr_o, p_addr);
            end
            if (!p_rst && p_if && p_stall && !p_rdr) begin
                check("stall_hold_valid", bus.if_valid_o, 1'b1);
                check("stall_hold_pc", bus.if_pc_o, p_pc);
                check("stall_hold_instr", bus.if_instr_o, p_ins);
                check("stall_hold_pred", bus.if_prdt_taken_o, p_pred);
            end
            if (!p_rst && p_rdr) begin
                check("redirect_flush", bus.if_valid_o, 1'b0);
                if (bus.imem_req_valid_o) check("redirect_req_addr", bus.imem_req_addr_o, p_tgt);
            end
            if (bus.imem_req_valid_o && ready_k) begin
                check("one_outstanding", pend, 1'b0);
                n_hs++;
                pend      = 1'b1;
                pend_addr = bus.imem_req_addr_o;
                due       = cyc + lat_k;
            end
            if (rdr_k) begin
                exp_pc = rdr_pc_k;
            end else if (bus.if_valid_o && !stall_k) begin
                ins = mem_rd(exp_pc);
                check("out_pc", bus.if_pc_o, exp_pc);
                check("out_instr", bus.if_instr_o, ins);
                exp_pc = ref_next(exp_pc, ins, tk);
                check("out_pred", bus.if_prdt_taken_o, tk);
                n_cons++;
            end
        end else begin
            exp_pc = 32'h0;
        end
        p_rst   = rst;
        p_req   = bus.imem_req_valid_o;
        p_rdy   = ready_k;
        p_addr  = bus.imem_req_addr_o;
        p_if    = bus.if_valid_o;
        p_stall = stall_k;
        p_rdr   = rdr_k;
        p_tgt   = rdr_pc_k;
        p_pc    = bus.if_pc_o;
        p_ins   = bus.if_instr_o;
        p_pred  = bus.if_prdt_taken_o;
    endtask

    task automatic wait_out(input string tag);
        int i = 0;
        do begin
            step();
            i++;
        end while (!bus.if_valid_o && i < 40);
        if (!bus.if_valid_o) check({tag, "_timeout"}, bus.if_valid_o, 1'b1);
    endtask

    task automatic wait_hs(input string tag);
        int i = 0;
        do begin
            step();
            i++;
        end while (!(bus.imem_req_valid_o && ready_k) && i < 40);
        if (!(bus.imem_req_valid_o && ready_k)) check({tag, "_timeout"}, bus.imem_req_valid_o, 1'b1);
    endtask

    initial begin
        logic [31:0] w, a;
        int          cnt, h0;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            case ($urandom % 8)
                0:       tbl[i] = {w[31:7], 7'b1101111};
                1:       tbl[i] = {1'b1, w[30:7], 7'b1100011};
                2:       tbl[i] = {1'b0, w[30:7], 7'b1100011};
                default: tbl[i] = {w[31:7], 7'b0010011};
            endcase
        end
        bus.stall_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = '0;
        bus.imem_req_ready_i = 1'b1; bus.imem_rsp_valid_i = 1'b0; bus.imem_rsp_data_i = '0;

        repeat (3) step();
        check("rst_req_valid", bus.imem_req_valid_o, 1'b0);
        check("rst_req_addr", bus.imem_req_addr_o, 32'h0);
        check("rst_if_valid", bus.if_valid_o, 1'b0);
        check("rst_if_pc", bus.if_pc_o, 32'h0);
        check("rst_if_instr", bus.if_instr_o, 32'h0);
        check("rst_if_pred", bus.if_prdt_taken_o, 1'b0);

        rst_k = 1'b0;
        step();
        check("first_req_valid", bus.imem_req_valid_o, 1'b1);
        check("first_req_addr", bus.imem_req_addr_o, 32'h0);
        step();
        step();
        check("first_out_valid", bus.if_valid_o, 1'b1);
        check("first_out_pc", bus.if_pc_o, 32'h0);
        cnt = 0;
        repeat (8) begin
            step();
            cnt += int'(bus.if_valid_o);
        end
        check("zero_wait_rate", cnt, 4);

        stall_k = 1'b1;
        repeat (6) step();
        check("skid_full_req_stop", bus.imem_req_valid_o, 1'b0);
        check("skid_full_out", bus.if_valid_o, 1'b1);
        stall_k = 1'b0;
        step();
        check("drain_out", bus.if_valid_o, 1'b1);
        step();
        check("drain_skid", bus.if_valid_o, 1'b1);

        lat_k = 3;
        step();
        wait_hs("slow_hs");
        rdr_k = 1'b1; rdr_pc_k = 32'h100;
        step();
        rdr_k = 1'b0; lat_k = 1;
        wait_out("drop_out");
        check("drop_then_pc", bus.if_pc_o, 32'h100);

        stall_k = 1'b1;
        begin
            int i = 0;
            do begin
                step();
                i++;
            end while (!(bus.if_valid_o && bus.imem_req_valid_o && ready_k) && i < 40);
            check("full_hs_seen", bus.if_valid_o && bus.imem_req_valid_o, 1'b1);
        end
        rdr_k = 1'b1; rdr_pc_k = 32'h200;
        step();
        rdr_k = 1'b0;
        step();
        check("coinc_flush", bus.if_valid_o, 1'b0);
        check("coinc_req_valid", bus.imem_req_valid_o, 1'b1);
        check("coinc_req_addr", bus.imem_req_addr_o, 32'h200);
        stall_k = 1'b0;
        wait_out("coinc_out");
        check("coinc_pc", bus.if_pc_o, 32'h200);

        ovr[32'h40] = 32'hFE000EE3;
        ovr[32'h50] = 32'h0100006F;
        rdr_k = 1'b1; rdr_pc_k = 32'h40;
        step();
        rdr_k = 1'b0;
        wait_out("beq_out");
        check("beq_pc", bus.if_pc_o, 32'h40);
        check("beq_pred", bus.if_prdt_taken_o, BPU);
        wait_out("beq_next");
        check("beq_next_pc", bus.if_pc_o, BPU ? 32'h3C : 32'h44);
        rdr_k = 1'b1; rdr_pc_k = 32'h50;
        step();
        rdr_k = 1'b0;
        wait_out("jal_out");
        check("jal_pred", bus.if_prdt_taken_o, BPU);
        wait_out("jal_next");
        check("jal_next_pc", bus.if_pc_o, BPU ? 32'h60 : 32'h54);

        ready_k = 1'b0;
        begin
            int i = 0;
            do begin
                step();
                i++;
            end while (!bus.imem_req_valid_o && i < 40);
        end
        a = bus.imem_req_addr_o;
        repeat (3) step();
        check("ready_low_valid", bus.imem_req_valid_o, 1'b1);
        check("ready_low_addr", bus.imem_req_addr_o, a);
        ready_k = 1'b1;
        h0 = n_hs;
        step();
        step();
        check("single_handshake", n_hs - h0, 1);

        lat_k = 2;
        wait_hs("late_hs");
        rst_k = 1'b1;
        step();
        rst_k = 1'b0; lat_k = 1;
        step();
        wait_out("late_out");
        check("late_rsp_ignored_pc", bus.if_pc_o, 32'h0);

        rnd_fill = 1'b1;
        rdr_k = 1'b1; rdr_pc_k = 32'h0;
        step();
        rdr_k = 1'b0;
        rnd = 1'b1;
        repeat (3000) step();
        rnd = 1'b0;
        check("random_progress", n_cons > 200, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit: produces the `pc`/`instr`/`prdt_taken` triple consumed by the IF/ID pipeline register and honours that register's `stall_i`. Generates sequential or statically predicted PCs, runs a single-outstanding request/response handshake to instruction memory, and buffers one returned instruction in a skid slot while the pipeline is stalled. Accepts a redirect from execute (mispredict/trap) that flushes all buffered and in-flight fetches.

## Interface
- `PC_WIDTH`, 32, PC and memory address width
- `INSTR_WIDTH`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall_i`  in  1  downstream stall; output held when 1
- `redirect_i`  in  1  flush and restart fetch
- `redirect_pc_i`  in  PC_WIDTH  restart address
- `imem_req_valid_o`  out  1  fetch request valid
- `imem_req_ready_i`  in  1  memory accepts request
- `imem_req_addr_o`  out  PC_WIDTH  fetch address
- `imem_rsp_valid_i`  in  1  response valid (no backpressure)
- `imem_rsp_data_i`  in  INSTR_WIDTH  fetched instruction
- `if_valid_o`  out  1  output triple valid
- `if_pc_o`  out  PC_WIDTH  PC of output instruction
- `if_instr_o`  out  INSTR_WIDTH  output instruction
- `if_prdt_taken_o`  out  1  static prediction for output instruction

## Operation
- State machine: `S_REQ` (request pending), `S_WAIT` (one request outstanding). Reset → `S_REQ`, `fetch_pc = RESET_PC`.
- `S_REQ`: `imem_req_valid_o = 1` with `addr = fetch_pc` iff skid slot empty and `redirect_i = 0`. Handshake (valid & ready) → `S_WAIT`. Valid, once raised, stays high with stable addr until ready (unless redirect).
- `S_WAIT`: on `imem_rsp_valid_i`: if `drop` flag set, discard, clear `drop`, → `S_REQ`. Else push {addr, data, pred} into the 2-entry output queue (out reg + skid), update `fetch_pc` to next PC, → `S_REQ`.
- Output queue: out reg drives `if_*_o`; consumed when `if_valid_o & ~stall_i`. Push when out reg empty or consumed same cycle → out reg; else → skid. Skid moves to out reg on consume. Never more than 2 entries (request gated on skid empty, one outstanding).
- Next PC (pred = 0): `pc + 4`, wrap modulo 2^PC_WIDTH.
- Redirect (highest priority): clears out reg and skid, `fetch_pc = redirect_pc_i`, `imem_req_valid_o = 0` that cycle. In `S_WAIT` with no response this cycle → set `drop`, stay `S_WAIT`. Response in same cycle as redirect → discarded, → `S_REQ`. Redirect while `drop` already set → keep `drop`, new target wins.
- `stall_i` affects only consumption; fetch continues until skid full.

## Timing
- Reset values: `imem_req_valid_o=0`, `imem_req_addr_o=0`, `if_valid_o=0`, `if_pc_o=0`, `if_instr_o=0`, `if_prdt_taken_o=0`, `drop=0`, queue empty.
- First request: cycle 1 after `rst` deasserts.
- Response in cycle N → `if_valid_o=1` in cycle N+1 (registered output).
- Zero-wait memory (ready=1, rsp next cycle): one instruction per 2 cycles.
- Redirect in cycle N → `if_valid_o=0` in N+1; new request at `redirect_pc_i` in N+1.
- Outputs stable while `if_valid_o & stall_i`.
- `rst` mid-transaction: state cleared; a late response while in `S_REQ` after reset is ignored.

## Configuration
- `IFU_STATIC_BPU_EN` defined: static predictor on captured instruction. JAL (opcode 7'b1101111) → pred=1, next = pc + J-imm. B-type (7'b1100011) with imm[12]=1 (backward) → pred=1, next = pc + B-imm. All else pred=0. Immediates sign-extended to PC_WIDTH.
- Undefined: `if_prdt_taken_o` tied 0, next PC always `pc + 4`; predictor logic absent.

## Test plan
- Reset release, ready=1, 1-cycle memory returning 32'h00000013 → outputs pc 0x0, 0x4, 0x8 each with instr 0x13, `if_valid_o` every other cycle, pred 0.
- `stall_i=1` for 6 cycles during streaming → out reg and skid fill (pcs 0x8, 0xC), request stops; release → 0x8 then 0xC emitted in order, no loss/duplicate.
- Redirect to 0x100 while request to 0x10 outstanding, response arrives 2 cycles later → response dropped, next `if_pc_o` = 0x100.
- Redirect coincident with response and with full skid → queue emptied, next request addr 0x200, no stale output.
- With `IFU_STATIC_BPU_EN`: instr 32'hFE000EE3 (beq x0,x0,-4) at 0x40 → `if_prdt_taken_o=1`, next fetch 0x3C; JAL +0x10 at 0x50 → next 0x60. Without macro → pred 0, next 0x44/0x54.
- imem_req_ready_i low 3 cycles → valid and addr held constant, single handshake on ready.
